baud_tick_gen: RTL

//  Multi-channel programmable baud/oversample timebase for UART peripherals.

---
 rtl/baud_tick_gen_pkg.sv | 20 ++
 rtl/baud_gen_ch.sv | 91 +++++++++
 rtl/baud_tick_gen.sv | 48 ++++
 3 files changed

// File: rtl/baud_tick_gen_pkg.sv
// Shared timebase constants and small helpers for the UART baud tick generator.
// The defaults give a 9600-baud, 16x-oversampled timebase from a 50 MHz clock.
package baud_tick_gen_pkg;

    localparam int CLK_HZ   = 50_000_000;
    localparam int BAUD_DEF = 9600;
    localparam int OVS_DEF  = 16;
    localparam int DIV_DEF  = CLK_HZ / (BAUD_DEF * OVS_DEF);

    // Channel-select width; a single channel still needs a 1-bit port.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A programmed divisor of 0 behaves like 1: one ovs tick every cycle.
    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/baud_gen_ch.sv
// One baud timebase channel: prescaler, oversample counter, strobes, derived
// clocks, and the pending-divisor register that is applied at safe boundaries.
module baud_gen_ch
    import baud_tick_gen_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int OVS     = OVS_DEF,
    parameter int DIV_RST = DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_pend,
    output logic             ovs_tick,
    output logic             baud_tick,
    output logic             ovs_clk,
    output logic             baud_clk
);

    localparam int OVS_W = (OVS > 2) ? $clog2(OVS) : 1;

    logic [CNT_W-1:0] div_q, pend_div, pre_cnt;
    logic [OVS_W-1:0] ovs_cnt;

    logic [CNT_W-1:0] div_eff, div_nxt, eff_nxt, pre_nxt;
    logic [OVS_W-1:0] ovs_nxt;
    logic             wrap, apply, ovs_last;

    always_comb begin
        div_eff  = CNT_W'(eff_div(32'(div_q)));
        wrap     = en && !sync && (pre_cnt == div_eff - CNT_W'(1));
        ovs_last = (ovs_cnt == OVS_W'(OVS - 1));
        // Divisor changes only land where the prescaler restarts anyway.
        apply    = cfg_pend && (sync || !en || wrap);
        div_nxt  = apply ? pend_div : div_q;
        eff_nxt  = CNT_W'(eff_div(32'(div_nxt)));
        pre_nxt  = wrap ? '0 : pre_cnt + CNT_W'(1);
        ovs_nxt  = ovs_cnt;
        if (wrap)
            ovs_nxt = ovs_last ? '0 : ovs_cnt + OVS_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q     <= CNT_W'(DIV_RST);
            pend_div  <= '0;
            cfg_pend  <= 1'b0;
            pre_cnt   <= '0;
            ovs_cnt   <= '0;
            ovs_tick  <= 1'b0;
            baud_tick <= 1'b0;
            ovs_clk   <= 1'b0;
            baud_clk  <= 1'b0;
        end else begin
            div_q <= div_nxt;
            // A write landing on an apply edge stays pending for the next one.
            if (cfg_we) begin
                pend_div <= cfg_div;
                cfg_pend <= 1'b1;
            end else if (apply) begin
                cfg_pend <= 1'b0;
            end

            if (sync) begin
                pre_cnt   <= '0;
                ovs_cnt   <= '0;
                ovs_tick  <= 1'b0;
                baud_tick <= 1'b0;
                ovs_clk   <= (eff_nxt > CNT_W'(1));
                baud_clk  <= 1'b1;
            end else if (!en) begin
                ovs_tick  <= 1'b0;
                baud_tick <= 1'b0;
                // Restart so the held count can never exceed a smaller new divisor.
                if (apply)
                    pre_cnt <= '0;
            end else begin
                pre_cnt   <= pre_nxt;
                ovs_cnt   <= ovs_nxt;
                ovs_tick  <= wrap;
                baud_tick <= wrap && ovs_last;
                ovs_clk   <= (pre_nxt < (eff_nxt >> 1));
                baud_clk  <= (ovs_nxt < OVS_W'(OVS / 2));
            end
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Multi-channel UART baud/oversample timebase: one baud_gen_ch per channel,
// with the shared divisor-write port decoded to a single channel.
module baud_tick_gen
    import baud_tick_gen_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 16,
    parameter int OVS     = OVS_DEF,
    parameter int DIV_RST = DIV_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           en,
    input  logic [NUM_CH-1:0]           sync,
    input  logic                        cfg_we,
    input  logic [ch_w(NUM_CH)-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]            cfg_div,
    output logic [NUM_CH-1:0]           cfg_pend,
    output logic [NUM_CH-1:0]           ovs_tick,
    output logic [NUM_CH-1:0]           baud_tick,
    output logic [NUM_CH-1:0]           ovs_clk,
    output logic [NUM_CH-1:0]           baud_clk
);

    localparam int CH_W = ch_w(NUM_CH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Out-of-range channel numbers match no instance and are dropped.
        baud_gen_ch #(
            .CNT_W   (CNT_W),
            .OVS     (OVS),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .en        (en[g]),
            .sync      (sync[g]),
            .cfg_we    (cfg_we && (cfg_ch == CH_W'(g))),
            .cfg_div   (cfg_div),
            .cfg_pend  (cfg_pend[g]),
            .ovs_tick  (ovs_tick[g]),
            .baud_tick (baud_tick[g]),
            .ovs_clk   (ovs_clk[g]),
            .baud_clk  (baud_clk[g])
        );
    end

endmodule
